// File: rtl/axi_sram_pkg.sv
// Shared types and constants for the AXI-Lite to narrow asynchronous SRAM bridge.
package axi_sram_pkg;

  localparam int unsigned WAIT_CNT_WIDTH = 4;
  localparam logic [1:0]  RESP_OKAY      = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    WR_SKIP,
    RD_ACCESS,
    BRESP,
    RRESP
  } state_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter timing the held phases of an SRAM access.
module sram_wait_counter
  import axi_sram_pkg::*;
(
  input  logic                      axi_clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      en,
  input  logic [WAIT_CNT_WIDTH-1:0] load_val,
  output logic                      done_c
);

  logic [WAIT_CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge axi_clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && !done_c) begin
      cnt_q <= cnt_q - WAIT_CNT_WIDTH'(1);
    end
  end

  assign done_c = (cnt_q == '0);

endmodule

// File: rtl/axi_sram_wide_controller.sv
// AXI-Lite slave splitting each AXI word into RATIO little-endian beats on a narrow
// asynchronous SRAM, with per-beat strobes, wait states and round-robin arbitration.
module axi_sram_wide_controller
  import axi_sram_pkg::*;
#(
  parameter  int unsigned AXI_ADDR_WIDTH  = 10,
  parameter  int unsigned AXI_DATA_WIDTH  = 16,
  parameter  int unsigned SRAM_DATA_WIDTH = 8,
  parameter  int unsigned WAIT_STATES     = 0,
  localparam int unsigned RATIO           = AXI_DATA_WIDTH / SRAM_DATA_WIDTH,
  localparam int unsigned IDX_WIDTH       = $clog2(RATIO),
  localparam int unsigned BEAT_WIDTH      = (IDX_WIDTH > 0) ? IDX_WIDTH : 1,
  localparam int unsigned SRAM_ADDR_WIDTH = AXI_ADDR_WIDTH + IDX_WIDTH
) (
  input  logic                       axi_clk,
  input  logic                       reset,
  input  logic [AXI_ADDR_WIDTH-1:0]  axi_awaddr,
  input  logic                       axi_awvalid,
  output logic                       axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]  axi_wdata,
  input  logic [RATIO-1:0]           axi_wstrb,
  input  logic                       axi_wvalid,
  output logic                       axi_wready,
  output logic [1:0]                 axi_bresp,
  output logic                       axi_bvalid,
  input  logic                       axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]  axi_araddr,
  input  logic                       axi_arvalid,
  output logic                       axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]  axi_rdata,
  output logic [1:0]                 axi_rresp,
  output logic                       axi_rvalid,
  input  logic                       axi_rready,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_io_addr,
  inout  wire  [SRAM_DATA_WIDTH-1:0] sram_io_data,
  output logic                       sram_io_we_n,
  output logic                       sram_io_oe_n,
  output logic                       sram_io_ce_n
);

  state_t                          state_q, state_d;
  logic [BEAT_WIDTH-1:0]           beat_q, beat_d, beat_inc;
  logic [AXI_ADDR_WIDTH-1:0]       addr_q, addr_src;
  logic [AXI_DATA_WIDTH-1:0]       wdata_q, wdata_src, rdata_q;
  logic [RATIO-1:0]                wstrb_q;
  logic [AXI_ADDR_WIDTH+BEAT_WIDTH-1:0] full_addr_d;
  logic [SRAM_DATA_WIDTH-1:0]      dout_q;
  logic                            drive_q;
  logic                            last_rd_q, settle_q, settle_d;
  logic                            wr_elig, rd_elig, wr_grant, rd_grant;
  logic                            capture, cnt_load, cnt_en, cnt_done_c, last_beat;

  sram_wait_counter u_wait (
    .axi_clk  (axi_clk),
    .reset    (reset),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (WAIT_CNT_WIDTH'(WAIT_STATES)),
    .done_c   (cnt_done_c)
  );

  assign wr_elig   = axi_awvalid && axi_wvalid;
  assign rd_elig   = axi_arvalid;
  assign beat_inc  = beat_q + BEAT_WIDTH'(1);
  assign last_beat = (beat_q == BEAT_WIDTH'(RATIO - 1));

  always_ff @(posedge axi_clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, beat sequencing and wait-counter control
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    settle_d = settle_q;
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    capture  = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!reset) begin
          if (wr_elig && (!rd_elig || last_rd_q)) wr_grant = 1'b1;
          else if (rd_elig)                       rd_grant = 1'b1;
        end
        if (wr_grant) begin
          beat_d  = '0;
          state_d = axi_wstrb[0] ? WR_SETUP : WR_SKIP;
        end else if (rd_grant) begin
          beat_d   = '0;
          settle_d = 1'b0;
          cnt_load = 1'b1;
          state_d  = RD_ACCESS;
        end
      end
      WR_SETUP: begin
        cnt_load = 1'b1;
        state_d  = WR_PULSE;
      end
      WR_PULSE: begin
        cnt_en = 1'b1;
        if (cnt_done_c) state_d = WR_HOLD;
      end
      WR_HOLD, WR_SKIP: begin
        if (last_beat) begin
          state_d = BRESP;
        end else begin
          beat_d  = beat_inc;
          state_d = wstrb_q[beat_inc] ? WR_SETUP : WR_SKIP;
        end
      end
      // One settle cycle after the counter expires gives WAIT_STATES+2 cycles per beat
      RD_ACCESS: begin
        cnt_en = 1'b1;
        if (settle_q) begin
          capture  = 1'b1;
          settle_d = 1'b0;
          if (last_beat) begin
            state_d = RRESP;
          end else begin
            beat_d   = beat_inc;
            cnt_load = 1'b1;
          end
        end else if (cnt_done_c) begin
          settle_d = 1'b1;
        end
      end
      BRESP:   if (axi_bready) state_d = IDLE;
      RRESP:   if (axi_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    axi_awready = wr_grant;
    axi_wready  = wr_grant;
    axi_arready = rd_grant;
    axi_bvalid  = (state_q == BRESP);
    axi_bresp   = RESP_OKAY;
    axi_rvalid  = (state_q == RRESP);
    axi_rresp   = RESP_OKAY;
    axi_rdata   = rdata_q;
  end

  assign addr_src    = wr_grant ? axi_awaddr : (rd_grant ? axi_araddr : addr_q);
  assign wdata_src   = wr_grant ? axi_wdata : wdata_q;
  assign full_addr_d = {addr_src, beat_d};

  // Pins are registered from the next state so they line up with the state they belong to
  always_ff @(posedge axi_clk) begin
    if (reset) begin
      beat_q       <= '0;
      settle_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
      last_rd_q    <= 1'b1;
      sram_io_addr <= '0;
      sram_io_we_n <= 1'b1;
      sram_io_oe_n <= 1'b1;
      sram_io_ce_n <= 1'b1;
      drive_q      <= 1'b0;
      dout_q       <= '0;
    end else begin
      beat_q   <= beat_d;
      settle_q <= settle_d;
      addr_q   <= addr_src;
      if (wr_grant) begin
        wdata_q   <= axi_wdata;
        wstrb_q   <= axi_wstrb;
        last_rd_q <= 1'b0;
      end
      if (rd_grant) last_rd_q <= 1'b1;
      if (capture) rdata_q[32'(beat_q) * SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH] <= sram_io_data;
      sram_io_addr <= SRAM_ADDR_WIDTH'(full_addr_d >> (BEAT_WIDTH - IDX_WIDTH));
      sram_io_ce_n <= !(state_d inside {WR_SETUP, WR_PULSE, WR_HOLD, RD_ACCESS});
      sram_io_we_n <= (state_d != WR_PULSE);
      sram_io_oe_n <= (state_d != RD_ACCESS);
      drive_q      <= (state_d inside {WR_SETUP, WR_PULSE, WR_HOLD});
      dout_q       <= wdata_src[32'(beat_d) * SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];
    end
  end

  assign sram_io_data = drive_q ? dout_q : {SRAM_DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_axi_sram_wide_controller.sv
// Directed bench: two controllers (0 and 2 wait states), each with a behavioural SRAM.
module tb_axi_sram_wide_controller;

  logic       axi_clk;
  logic       reset;
  logic [9:0] awaddr[2], araddr[2];
  logic       awvalid[2], awready[2], wvalid[2], wready[2];
  logic [15:0] wdata[2], rdata[2];
  logic [1:0] wstrb[2], bresp[2], rresp[2];
  logic       bvalid[2], bready[2], arvalid[2], arready[2], rvalid[2], rready[2];
  logic [10:0] sa[2];
  logic       we_n[2], oe_n[2], ce_n[2];
  wire  [7:0] sd0, sd1;
  logic [7:0] mem0[2048];
  logic [7:0] mem1[2048];

  int checks = 0;
  int errors = 0;
  logic overlap = 1'b0;
  int run1 = 0;
  int runs1[$];

  typedef struct {
    bit          wr;
    logic [9:0]  addr;
    logic [15:0] data;
    logic [1:0]  strb;
    int          lat;
  } vec_t;
  vec_t vecs[10];

  axi_sram_wide_controller #(.WAIT_STATES(0)) dut0 (
    .axi_clk(axi_clk), .reset(reset),
    .axi_awaddr(awaddr[0]), .axi_awvalid(awvalid[0]), .axi_awready(awready[0]),
    .axi_wdata(wdata[0]), .axi_wstrb(wstrb[0]), .axi_wvalid(wvalid[0]), .axi_wready(wready[0]),
    .axi_bresp(bresp[0]), .axi_bvalid(bvalid[0]), .axi_bready(bready[0]),
    .axi_araddr(araddr[0]), .axi_arvalid(arvalid[0]), .axi_arready(arready[0]),
    .axi_rdata(rdata[0]), .axi_rresp(rresp[0]), .axi_rvalid(rvalid[0]), .axi_rready(rready[0]),
    .sram_io_addr(sa[0]), .sram_io_data(sd0),
    .sram_io_we_n(we_n[0]), .sram_io_oe_n(oe_n[0]), .sram_io_ce_n(ce_n[0])
  );

  axi_sram_wide_controller #(.WAIT_STATES(2)) dut1 (
    .axi_clk(axi_clk), .reset(reset),
    .axi_awaddr(awaddr[1]), .axi_awvalid(awvalid[1]), .axi_awready(awready[1]),
    .axi_wdata(wdata[1]), .axi_wstrb(wstrb[1]), .axi_wvalid(wvalid[1]), .axi_wready(wready[1]),
    .axi_bresp(bresp[1]), .axi_bvalid(bvalid[1]), .axi_bready(bready[1]),
    .axi_araddr(araddr[1]), .axi_arvalid(arvalid[1]), .axi_arready(arready[1]),
    .axi_rdata(rdata[1]), .axi_rresp(rresp[1]), .axi_rvalid(rvalid[1]), .axi_rready(rready[1]),
    .sram_io_addr(sa[1]), .sram_io_data(sd1),
    .sram_io_we_n(we_n[1]), .sram_io_oe_n(oe_n[1]), .sram_io_ce_n(ce_n[1])
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  // Behavioural asynchronous SRAMs
  assign sd0 = (!ce_n[0] && !oe_n[0]) ? mem0[sa[0]] : 8'bz;
  assign sd1 = (!ce_n[1] && !oe_n[1]) ? mem1[sa[1]] : 8'bz;
  always @(posedge axi_clk) if (!ce_n[0] && !we_n[0]) mem0[sa[0]] <= sd0;
  always @(posedge axi_clk) if (!ce_n[1] && !we_n[1]) mem1[sa[1]] <= sd1;

  always @(negedge axi_clk) begin
    if ((!oe_n[0] && !we_n[0]) || (!oe_n[1] && !we_n[1])) overlap <= 1'b1;
    if (!we_n[1]) run1 <= run1 + 1;
    else if (run1 != 0) begin
      runs1.push_back(run1);
      run1 <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_write(input int d, input logic [9:0] a, input logic [15:0] data,
                          input logic [1:0] s, input int hold,
                          output int lat, output logic [1:0] resp);
    int n;
    @(negedge axi_clk);
    awaddr[d] = a; wdata[d] = data; wstrb[d] = s;
    awvalid[d] = 1'b1; wvalid[d] = 1'b1; bready[d] = (hold == 0);
    n = 0;
    #1;
    while (!awready[d] && n < 100) begin @(negedge axi_clk); #1; n++; end
    chk("aw_grant", 32'(awready[d]), 32'd1);
    @(posedge axi_clk); #1;
    awvalid[d] = 1'b0; wvalid[d] = 1'b0;
    lat = 0;
    do begin @(negedge axi_clk); lat++; end while (!bvalid[d] && lat < 500);
    resp = bresp[d];
    for (int i = 0; i < hold; i++) begin
      #1;
      chk("hold_bvalid", 32'(bvalid[d]), 32'd1);
      chk("hold_awready", 32'(awready[d]), 32'd0);
      chk("hold_arready", 32'(arready[d]), 32'd0);
      @(negedge axi_clk);
    end
    bready[d] = 1'b1;
  endtask

  task automatic do_read(input int d, input logic [9:0] a,
                         output int lat, output logic [15:0] data, output logic [1:0] resp);
    int n;
    @(negedge axi_clk);
    araddr[d] = a; arvalid[d] = 1'b1; rready[d] = 1'b1;
    n = 0;
    #1;
    while (!arready[d] && n < 100) begin @(negedge axi_clk); #1; n++; end
    chk("ar_grant", 32'(arready[d]), 32'd1);
    @(posedge axi_clk); #1;
    arvalid[d] = 1'b0;
    lat = 0;
    do begin @(negedge axi_clk); lat++; end while (!rvalid[d] && lat < 500);
    data = rdata[d];
    resp = rresp[d];
  endtask

  initial begin
    int lat;
    int n;
    int nw;
    logic [1:0] resp;
    logic [15:0] rd;
    logic bv, both;
    int grants[$];
    logic [15:0] rds[$];

    vecs[0] = '{1'b1, 10'h0B0, 16'hBEEF, 2'b11, 7};
    vecs[1] = '{1'b0, 10'h0B0, 16'hBEEF, 2'b00, 5};
    vecs[2] = '{1'b1, 10'h0B0, 16'h1234, 2'b01, 5};
    vecs[3] = '{1'b0, 10'h0B0, 16'hBE34, 2'b00, 5};
    vecs[4] = '{1'b1, 10'h3FF, 16'hCAFE, 2'b10, 5};
    vecs[5] = '{1'b0, 10'h3FF, 16'hCA00, 2'b00, 5};
    vecs[6] = '{1'b1, 10'h000, 16'h5678, 2'b00, 3};
    vecs[7] = '{1'b0, 10'h000, 16'h0000, 2'b00, 5};
    vecs[8] = '{1'b1, 10'h000, 16'h9ABC, 2'b10, 5};
    vecs[9] = '{1'b0, 10'h000, 16'h9A00, 2'b00, 5};

    for (int i = 0; i < 2048; i++) begin mem0[i] = 8'h00; mem1[i] = 8'h00; end
    for (int d = 0; d < 2; d++) begin
      awaddr[d] = '0; araddr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
      awvalid[d] = 1'b1; wvalid[d] = 1'b1; arvalid[d] = 1'b1;
      bready[d] = 1'b1; rready[d] = 1'b1;
    end
    reset = 1'b1;
    repeat (3) @(negedge axi_clk);
    #1;
    chk("rst_awready", 32'(awready[0]), 32'd0);
    chk("rst_arready", 32'(arready[0]), 32'd0);
    chk("rst_wready", 32'(wready[1]), 32'd0);
    chk("rst_bvalid", 32'(bvalid[0]), 32'd0);
    chk("rst_rvalid", 32'(rvalid[0]), 32'd0);
    chk("rst_bresp", 32'(bresp[0]), 32'd0);
    chk("rst_rdata", 32'(rdata[0]), 32'd0);
    chk("rst_strobes", {29'd0, we_n[0], oe_n[0], ce_n[0]}, 32'd7);
    chk("rst_addr", 32'(sa[0]), 32'd0);
    for (int d = 0; d < 2; d++) begin awvalid[d] = 1'b0; wvalid[d] = 1'b0; arvalid[d] = 1'b0; end
    @(negedge axi_clk);
    reset = 1'b0;

    // Table of single transactions on the zero-wait controller
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) begin
        do_write(0, vecs[i].addr, vecs[i].data, vecs[i].strb, 0, lat, resp);
        chk($sformatf("vec%0d_wr_lat", i), 32'(lat), 32'(vecs[i].lat));
        chk($sformatf("vec%0d_bresp", i), 32'(resp), 32'd0);
      end else begin
        do_read(0, vecs[i].addr, lat, rd, resp);
        chk($sformatf("vec%0d_rd_lat", i), 32'(lat), 32'(vecs[i].lat));
        chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].data));
        chk($sformatf("vec%0d_rresp", i), 32'(resp), 32'd0);
      end
      if (i == 0) begin
        chk("mem_160_first", 32'(mem0[11'h160]), 32'hEF);
        chk("mem_161_first", 32'(mem0[11'h161]), 32'hBE);
      end
    end
    chk("mem_160", 32'(mem0[11'h160]), 32'h34);
    chk("mem_161", 32'(mem0[11'h161]), 32'hBE);
    chk("mem_7fe", 32'(mem0[11'h7FE]), 32'h00);
    chk("mem_7ff", 32'(mem0[11'h7FF]), 32'hCA);

    // Two wait states: 3-cycle write pulses and longer latencies
    do_write(1, 10'h001, 16'hA55A, 2'b11, 0, lat, resp);
    chk("w2_wr_lat", 32'(lat), 32'd11);
    chk("w2_pulses", 32'(runs1.size()), 32'd2);
    for (int i = 0; i < 2; i++) chk($sformatf("w2_pulse%0d", i), 32'(i < runs1.size() ? runs1[i] : 0), 32'd3);
    do_read(1, 10'h001, lat, rd, resp);
    chk("w2_rd_lat", 32'(lat), 32'd9);
    chk("w2_rdata", 32'(rd), 32'hA55A);
    chk("w2_mem_lo", 32'(mem1[11'h002]), 32'h5A);
    chk("w2_mem_hi", 32'(mem1[11'h003]), 32'hA5);

    // Held response blocks both channels; pending read grants the cycle after release
    araddr[0] = 10'h055; arvalid[0] = 1'b1;
    do_write(0, 10'h055, 16'h7E81, 2'b11, 10, lat, resp);
    chk("bhold_lat", 32'(lat), 32'd7);
    @(negedge axi_clk); #1;
    chk("bhold_next_grant", 32'(arready[0]), 32'd1);
    @(posedge axi_clk); #1;
    arvalid[0] = 1'b0;
    n = 0;
    do begin @(negedge axi_clk); n++; end while (!rvalid[0] && n < 100);
    chk("bhold_rdata", 32'(rdata[0]), 32'h7E81);

    // Reset in the middle of a write pulse
    @(negedge axi_clk);
    awaddr[0] = 10'h020; wdata[0] = 16'h4444; wstrb[0] = 2'b11;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1;
    #1;
    chk("mr_awready", 32'(awready[0]), 32'd1);
    @(posedge axi_clk); #1;
    awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    @(negedge axi_clk);
    @(negedge axi_clk);
    chk("mr_we_low", 32'(we_n[0]), 32'd0);
    reset = 1'b1;
    @(posedge axi_clk); #1;
    chk("mr_we_high", 32'(we_n[0]), 32'd1);
    chk("mr_ce_high", 32'(ce_n[0]), 32'd1);
    @(negedge axi_clk);
    reset = 1'b0;
    bv = 1'b0;
    repeat (15) begin @(negedge axi_clk); if (bvalid[0]) bv = 1'b1; end
    chk("mr_no_bvalid", 32'(bv), 32'd0);

    // Repeated ties from reset: write first, then alternate
    awaddr[0] = 10'h010; araddr[0] = 10'h010; wdata[0] = 16'h1111; wstrb[0] = 2'b11;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1; arvalid[0] = 1'b1;
    nw = 0; both = 1'b0;
    for (int c = 0; c < 300 && rds.size() < 2; c++) begin
      if (grants.size() >= 4) begin awvalid[0] = 1'b0; wvalid[0] = 1'b0; arvalid[0] = 1'b0; end
      if (nw == 1) wdata[0] = 16'h2222;
      #1;
      if (awready[0]) begin grants.push_back(0); nw++; end
      if (arready[0]) grants.push_back(1);
      if (awready[0] && arready[0]) both = 1'b1;
      if (rvalid[0]) rds.push_back(rdata[0]);
      @(negedge axi_clk);
    end
    chk("tie_both_ready", 32'(both), 32'd0);
    chk("tie_grant_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("tie_grant%0d", i), 32'(i < grants.size() ? grants[i] : 9), 32'(i % 2));
    chk("tie_rdata0", 32'(rds.size() > 0 ? rds[0] : 16'h0), 32'h1111);
    chk("tie_rdata1", 32'(rds.size() > 1 ? rds[1] : 16'h0), 32'h2222);

    chk("oe_we_overlap", 32'(overlap), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
